// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_ctrl_pkg
// Purpose  : State encoding and width helpers shared by the SR latch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Timer must hold the larger of the two phase lengths.
    function automatic int timer_width(input int pulse_cyc, input int gap_cyc);
        int max_cyc;
        max_cyc = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
        return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr_latch_seq_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin arbiter; pointer advances past the winner on grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int REQ_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_N-1:0] req,
    input  logic             advance,
    output logic [REQ_N-1:0] gnt
);

    localparam int C_PTR_W = idx_width(REQ_N);

    logic [C_PTR_W-1:0] ptr_q;
    logic [C_PTR_W-1:0] ptr_d;
    int                 w_best;
    int                 w_win;
    int                 w_dist;

    // Winner is the requester with the smallest circular distance from the pointer.
    always_comb begin
        w_best = REQ_N;
        w_win  = 0;
        w_dist = 0;
        gnt    = '0;
        ptr_d  = ptr_q;
        for (int i = 0; i < REQ_N; i++) begin
            w_dist = (i + REQ_N - int'(ptr_q)) % REQ_N;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = i;
            end
        end
        for (int i = 0; i < REQ_N; i++) begin
            gnt[i] = (w_best < REQ_N) && (i == w_win);
        end
        if (advance && (w_best < REQ_N)) begin
            ptr_d = C_PTR_W'((w_win + 1) % REQ_N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sr_latch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_seq_ctrl
// Purpose  : Shares an SR latch bank between requesters: pulse, settle, read back.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_seq_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int NUM_LATCH = 8,
    parameter int REQ_N     = 4,
    parameter int IDX_W     = idx_width(NUM_LATCH),
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REQ_N-1:0]       req,
    input  logic [REQ_N-1:0]       cmd_set,
    input  logic [REQ_N*IDX_W-1:0] cmd_idx,
    output logic [REQ_N-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   err_stky,
    output logic [NUM_LATCH-1:0]   latch_S,
    output logic [NUM_LATCH-1:0]   latch_R,
    input  logic [NUM_LATCH-1:0]   latch_Q
);

    localparam int               C_TMR_W     = timer_width(PULSE_CYC, GAP_CYC);
    localparam logic [C_TMR_W-1:0] C_TMR_ONE   = C_TMR_W'(1);
    localparam logic [C_TMR_W-1:0] C_TMR_PULSE = C_TMR_W'(PULSE_CYC);
    localparam logic [C_TMR_W-1:0] C_TMR_GAP   = C_TMR_W'(GAP_CYC);

    state_t               state_q,    state_d;
    logic [C_TMR_W-1:0]   timer_q,    timer_d;
    logic                 set_q,      set_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic                 bad_q,      bad_d;
    logic [REQ_N-1:0]     gnt_q,      gnt_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 err_q,      err_d;
    logic                 err_stky_q, err_stky_d;
    logic [NUM_LATCH-1:0] latch_s_q,  latch_s_d;
    logic [NUM_LATCH-1:0] latch_r_q,  latch_r_d;

    logic [REQ_N-1:0]     w_arb_gnt;
    logic                 w_advance;
    logic                 w_q_sel;

    assign w_advance = (state_q == ST_IDLE);

    rr_arbiter #(
        .REQ_N   (REQ_N)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (w_advance),
        .gnt     (w_arb_gnt)
    );

    always_comb begin
        w_q_sel = 1'b0;
        for (int i = 0; i < NUM_LATCH; i++) begin
            if (int'(idx_q) == i) w_q_sel = latch_Q[i];
        end
    end

    // S/R are registered, so the bank sees the pulse one cycle after the state.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        set_d      = set_q;
        idx_d      = idx_q;
        bad_d      = bad_q;
        gnt_d      = '0;
        busy_d     = (state_q != ST_IDLE);
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_stky_d = err_stky_q;
        latch_s_d  = '0;
        latch_r_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d = w_arb_gnt;
                    for (int i = 0; i < REQ_N; i++) begin
                        if (w_arb_gnt[i]) begin
                            set_d = cmd_set[i];
                            idx_d = cmd_idx[i*IDX_W +: IDX_W];
                        end
                    end
                    bad_d   = (int'(idx_d) >= NUM_LATCH);
                    timer_d = C_TMR_PULSE;
                    state_d = bad_d ? ST_CHECK : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                for (int i = 0; i < NUM_LATCH; i++) begin
                    latch_s_d[i] =  set_q && (int'(idx_q) == i);
                    latch_r_d[i] = !set_q && (int'(idx_q) == i);
                end
                if (timer_q <= C_TMR_ONE) begin
                    timer_d = C_TMR_GAP;
                    state_d = ST_SETTLE;
                end else begin
                    timer_d = timer_q - C_TMR_ONE;
                end
            end
            ST_SETTLE: begin
                if (timer_q <= C_TMR_ONE) begin
                    timer_d = '0;
                    state_d = ST_CHECK;
                end else begin
                    timer_d = timer_q - C_TMR_ONE;
                end
            end
            ST_CHECK: begin
                done_d     = 1'b1;
                err_d      = bad_q | (w_q_sel != set_q);
                err_stky_d = err_stky_q | err_d;
                timer_d    = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            set_q      <= 1'b0;
            idx_q      <= '0;
            bad_q      <= 1'b0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_stky_q <= 1'b0;
            latch_s_q  <= '0;
            latch_r_q  <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            set_q      <= set_d;
            idx_q      <= idx_d;
            bad_q      <= bad_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_stky_q <= err_stky_d;
            latch_s_q  <= latch_s_d;
            latch_r_q  <= latch_r_d;
        end
    end

    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_stky = err_stky_q;
    assign latch_S  = latch_s_q;
    assign latch_R  = latch_r_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch_seq_ctrl
// Purpose  : Directed and random checks of the sequencer against a bank model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_seq_ctrl;

    localparam int NUM_LATCH = 6;
    localparam int REQ_N     = 4;
    localparam int IDX_W     = 3;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [REQ_N-1:0]       req;
    logic [REQ_N-1:0]       cmd_set;
    logic [REQ_N*IDX_W-1:0] cmd_idx;
    logic [REQ_N-1:0]       gnt;
    logic                   busy, done, err, err_stky;
    logic [NUM_LATCH-1:0]   latch_S, latch_R, latch_Q;
    logic [NUM_LATCH-1:0]   bank  = '0;
    logic [NUM_LATCH-1:0]   fault = '0;

    always #5 clk = ~clk;

    sr_latch_seq_ctrl #(
        .NUM_LATCH (NUM_LATCH),
        .REQ_N     (REQ_N),
        .IDX_W     (IDX_W),
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cmd_set  (cmd_set),
        .cmd_idx  (cmd_idx),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_stky (err_stky),
        .latch_S  (latch_S),
        .latch_R  (latch_R),
        .latch_Q  (latch_Q)
    );

    // Latch bank: the fault mask forces readback to 0 without touching storage.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_LATCH; i++) begin
            if (latch_S[i])      bank[i] <= 1'b1;
            else if (latch_R[i]) bank[i] <= 1'b0;
        end
    end
    assign latch_Q = bank & ~fault;

    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   cyc      = 0;
    int                   p        = 0;
    bit                   op_active = 0;
    int                   op_t, op_len, op_idx;
    bit                   op_set, op_bad;
    bit [NUM_LATCH-1:0]   mbank  = '0;
    bit                   m_stky = 0;
    bit                   m_gnt_now, m_done_now;
    int                   dut_gnt_cyc, dut_done_cyc, dut_done_cnt;
    bit                   dut_done_err;
    int                   dut_glog[$];
    int                   dut_gap[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // One clock: predict this cycle's outputs from the inputs sampled at the edge.
    task automatic step();
        logic [REQ_N-1:0]     e_gnt;
        logic                 e_busy, e_done, e_err;
        logic [NUM_LATCH-1:0] e_s, e_r;
        int                   age, k, c;
        bit                   found;
        @(posedge clk);
        #1;
        cyc++;
        e_gnt = '0; e_busy = 0; e_done = 0; e_err = 0; e_s = '0; e_r = '0;
        m_gnt_now = 0; m_done_now = 0;
        if (rst) begin
            op_active = 0;
            p         = 0;
            m_stky    = 0;
        end else if (op_active) begin
            age    = cyc - op_t;
            e_busy = 1;
            if (!op_bad && age <= PULSE_CYC) begin
                if (op_set) e_s[op_idx] = 1'b1;
                else        e_r[op_idx] = 1'b1;
                mbank[op_idx] = op_set;
            end
            if (age == op_len) begin
                e_done = 1;
                if (op_bad) e_err = 1;
                else        e_err = ((mbank[op_idx] && !fault[op_idx]) != op_set);
                m_stky     = m_stky | e_err;
                op_active  = 0;
                m_done_now = 1;
            end
        end else if (req != '0) begin
            found = 0;
            k     = 0;
            for (int j = 0; j < REQ_N; j++) begin
                c = (p + j) % REQ_N;
                if (!found && req[c]) begin
                    found = 1;
                    k     = c;
                end
            end
            e_gnt[k]  = 1'b1;
            p         = (k + 1) % REQ_N;
            op_active = 1;
            op_t      = cyc;
            op_set    = cmd_set[k];
            op_idx    = int'(cmd_idx[k*IDX_W +: IDX_W]);
            op_bad    = (op_idx >= NUM_LATCH);
            op_len    = op_bad ? 1 : PULSE_CYC + GAP_CYC + 1;
            m_gnt_now = 1;
        end

        check("gnt",      32'(gnt),      32'(e_gnt));
        check("busy",     32'(busy),     32'(e_busy));
        check("done",     32'(done),     32'(e_done));
        check("err",      32'(err),      32'(e_err));
        check("err_stky", 32'(err_stky), 32'(m_stky));
        check("latch_S",  32'(latch_S),  32'(e_s));
        check("latch_R",  32'(latch_R),  32'(e_r));
        check("s_and_r",  32'(latch_S & latch_R), 32'd0);
        check("one_drv",  32'($countones(latch_S | latch_R) <= 1), 32'd1);
        if (e_done) check("bank", 32'(bank), 32'(mbank));

        if (gnt != '0) begin
            for (int i = 0; i < REQ_N; i++) if (gnt[i]) dut_glog.push_back(i);
            dut_gap.push_back(cyc - dut_done_cyc);
            dut_gnt_cyc = cyc;
        end
        if (done) begin
            dut_done_cyc = cyc;
            dut_done_err = err;
            dut_done_cnt++;
        end
    endtask

    task automatic do_op(input int k, input bit set, input int idx);
        int start_cnt;
        start_cnt = dut_done_cnt;
        req[k]    = 1'b1;
        cmd_set[k] = set;
        cmd_idx[k*IDX_W +: IDX_W] = IDX_W'(idx);
        for (int n = 0; n < 20; n++) begin
            step();
            if (gnt[k]) req[k] = 1'b0;
            if (m_done_now) break;
        end
        req[k] = 1'b0;
        check("op_done_seen", 32'(dut_done_cnt - start_cnt), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && op_active; n++) step();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_order[5];
        int cnt;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = '0; cmd_set = '0; cmd_idx = '0;
        dut_gnt_cyc = 0; dut_done_cyc = 0; dut_done_cnt = 0; dut_done_err = 0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Set latch 3 from requester 0.
        do_op(0, 1'b1, 3);
        check("t1_latency", 32'(dut_done_cyc - dut_gnt_cyc), 32'd4);
        check("t1_err",     32'(dut_done_err), 32'd0);
        check("t1_q3",      32'(bank[3]), 32'd1);

        // Contention: all requesters held from reset.
        pulse_rst();
        dut_glog.delete();
        dut_gap.delete();
        cmd_set = 4'b0101;
        cmd_idx = {3'd4, 3'd2, 3'd1, 3'd0};
        req = 4'b1111;
        for (int n = 0; n < 100 && dut_glog.size() < 5; n++) step();
        req = '0;
        drain();
        check("t2_ngrant", 32'(dut_glog.size()), 32'd5);
        for (int i = 0; i < 5 && i < dut_glog.size(); i++) begin
            check("t2_order", 32'(dut_glog[i]), 32'(exp_order[i]));
            if (i > 0) check("t2_gap", 32'(dut_gap[i]), 32'd1);
        end

        // Readback fault on latch 5.
        fault = 6'b100000;
        do_op(1, 1'b1, 5);
        check("t3_err", 32'(dut_done_err), 32'd1);
        check("t3_latency", 32'(dut_done_cyc - dut_gnt_cyc), 32'd4);
        fault = '0;
        repeat (3) step();
        check("t3_stky", 32'(err_stky), 32'd1);
        pulse_rst();
        check("t3_stky_clr", 32'(err_stky), 32'd0);

        // Out-of-range index.
        do_op(2, 1'b1, 7);
        check("t4_latency", 32'(dut_done_cyc - dut_gnt_cyc), 32'd1);
        check("t4_err", 32'(dut_done_err), 32'd1);

        // Reset in the cycle after a reset-op grant on latch 2.
        pulse_rst();
        do_op(0, 1'b1, 2);
        req[1] = 1'b1; cmd_set[1] = 1'b0; cmd_idx[5:3] = 3'd2;
        for (int n = 0; n < 10 && !m_gnt_now; n++) step();
        req[1] = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_r", 32'(latch_R), 32'd0);
        cnt = dut_done_cnt;
        repeat (6) step();
        check("t5_nodone", 32'(dut_done_cnt - cnt), 32'd0);
        check("t5_q2", 32'(bank[2]), 32'd1);
        dut_glog.delete();
        cmd_set = 4'b0000; cmd_idx = {3'd1, 3'd1, 3'd1, 3'd1};
        req = 4'b0101;
        for (int n = 0; n < 10 && dut_glog.size() == 0; n++) step();
        req = '0;
        check("t5_ptr", (dut_glog.size() > 0) ? 32'(dut_glog[0]) : 32'hFFFF_FFFF, 32'd0);
        drain();

        // Random traffic with occasional withdrawals, resets and readback faults.
        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 999) == 0);
            for (int k = 0; k < REQ_N; k++) begin
                if (gnt[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 3) == 0) begin
                    req[k]     = 1'b1;
                    cmd_set[k] = 1'($urandom);
                    cmd_idx[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 7));
                end else if (req[k] && $urandom_range(0, 63) == 0) begin
                    req[k] = 1'b0;
                end
            end
            if (!op_active && $urandom_range(0, 49) == 0)
                fault = ($urandom_range(0, 1) == 0) ? '0 : NUM_LATCH'(1 << $urandom_range(0, NUM_LATCH-1));
            step();
        end
        rst = 1'b0; req = '0;
        drain();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
